matvec_scheduler: RTL and testbench

Sequencing controller that computes a matrix-vector product on the shared combinational `vector_dot_product` unit. It latches an operand vector on `start` and fetches ROWS matrix rows one at a time over a request/valid handshake. For each row it runs one dot product and streams the per-row results out over a valid/ready interface. It sits between the accelerator's row-buffer memory and the result collector.

---
 rtl/matvec_pkg.sv | 21 ++
 rtl/vector_dot_product.sv | 19 +
 rtl/matvec_scheduler.sv | 119 +++++++++++
 tb/tb_matvec_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared types and constants for the matrix-vector scheduler: element width,
// FSM state encoding and the index-width helper used for row addressing.
package matvec_pkg;

  localparam int DATA_W = 31;

  typedef logic [DATA_W-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    CALC,
    OUT
  } mvs_state_t;

  // A single-row job still needs a 1-bit address port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vector_dot_product.sv
// Combinational dot product of two packed vectors; products and the running
// sum wrap modulo 2^DATA_W.
module vector_dot_product #(
  parameter int VECTOR_SIZE = 4,
  parameter int DATA_W      = 31
) (
  input  logic [VECTOR_SIZE-1:0][DATA_W-1:0] vec_a,
  input  logic [VECTOR_SIZE-1:0][DATA_W-1:0] vec_b,
  output logic [DATA_W-1:0]                  result
);

  always_comb begin
    result = '0;
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      result = result + vec_a[i] * vec_b[i];
    end
  end

endmodule

// File: rtl/matvec_scheduler.sv
// Sequences a matrix-vector product: latches the operand vector, fetches one
// row at a time, computes its dot product and streams per-row results out.
module matvec_scheduler #(
  parameter int VECTOR_SIZE = 4,
  parameter int ROWS        = 4,
  parameter int DATA_W      = matvec_pkg::DATA_W
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [VECTOR_SIZE-1:0][DATA_W-1:0]      vec_in,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    row_req,
  output logic [matvec_pkg::idx_width(ROWS)-1:0]  row_addr,
  input  logic                                    row_vld,
  input  logic [VECTOR_SIZE-1:0][DATA_W-1:0]      row_data,
  output logic                                    res_valid,
  input  logic                                    res_ready,
  output logic [DATA_W-1:0]                       res_data,
  output logic [matvec_pkg::idx_width(ROWS)-1:0]  res_index
);

  import matvec_pkg::*;

  localparam int            IW       = idx_width(ROWS);
  localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);

  mvs_state_t state_q, state_d;

  logic [VECTOR_SIZE-1:0][DATA_W-1:0] vec_q;
  logic [VECTOR_SIZE-1:0][DATA_W-1:0] row_q;
  logic [IW-1:0]                      idx_q;
  logic [IW-1:0]                      res_index_q;
  logic [DATA_W-1:0]                  res_data_q;
  logic                               done_q;
  logic [DATA_W-1:0]                  dot;

  logic lastRow;
  logic loadVec;
  logic loadRow;
  logic loadRes;
  logic advance;
  logic finish;

  assign lastRow = (idx_q == LAST_IDX);

  vector_dot_product #(
    .VECTOR_SIZE(VECTOR_SIZE),
    .DATA_W     (DATA_W)
  ) u_dot (
    .vec_a (vec_q),
    .vec_b (row_q),
    .result(dot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = REQ;
      REQ:     if (row_vld)   state_d = CALC;
      CALC:                   state_d = OUT;
      OUT:     if (res_ready) state_d = lastRow ? IDLE : REQ;
      default:                state_d = IDLE;
    endcase
  end

  // Status outputs and datapath enables are all decoded from the current state.
  always_comb begin
    busy      = (state_q != IDLE);
    row_req   = (state_q == REQ);
    res_valid = (state_q == OUT);
    loadVec   = (state_q == IDLE) && start;
    loadRow   = (state_q == REQ) && row_vld;
    loadRes   = (state_q == CALC);
    advance   = (state_q == OUT) && res_ready && !lastRow;
    finish    = (state_q == OUT) && res_ready && lastRow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q       <= '0;
      row_q       <= '0;
      idx_q       <= '0;
      res_data_q  <= '0;
      res_index_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= finish;
      if (loadVec) begin
        vec_q <= vec_in;
        idx_q <= '0;
      end else if (advance) begin
        idx_q <= idx_q + IW'(1);
      end
      if (loadRow) begin
        row_q <= row_data;
      end
      if (loadRes) begin
        res_data_q  <= dot;
        res_index_q <= idx_q;
      end
    end
  end

  assign row_addr  = idx_q;
  assign res_data  = res_data_q;
  assign res_index = res_index_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matvec_scheduler.sv
// Directed plus randomized bench for matvec_scheduler with a ROWS=2 job size,
// checked against an arithmetic dot-product reference.
module tb_matvec_scheduler;

  localparam int VS   = 4;
  localparam int ROWS = 2;
  localparam int DW   = 31;

  typedef logic [VS-1:0][DW-1:0] vecT;

  logic          clk;
  logic          rst;
  logic          start;
  vecT           vec_in;
  logic          busy;
  logic          done;
  logic          row_req;
  logic [0:0]    row_addr;
  logic          row_vld;
  vecT           row_data;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [0:0]    res_index;

  int compared   = 0;
  int mismatched = 0;

  matvec_scheduler #(
    .VECTOR_SIZE(VS),
    .ROWS       (ROWS),
    .DATA_W     (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vec_in   (vec_in),
    .busy     (busy),
    .done     (done),
    .row_req  (row_req),
    .row_addr (row_addr),
    .row_vld  (row_vld),
    .row_data (row_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_index(res_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: sum of element products, reduced modulo 2^DW at the end.
  function automatic logic [63:0] refDot(input vecT v, input vecT r);
    longint unsigned s;
    longint unsigned a;
    longint unsigned b;
    s = 0;
    for (int i = 0; i < VS; i++) begin
      a = longint'(v[i]);
      b = longint'(r[i]);
      s = s + a * b;
    end
    return s % (64'd1 << DW);
  endfunction

  function automatic vecT randVec();
    vecT v;
    for (int i = 0; i < VS; i++) v[i] = DW'($urandom);
    return v;
  endfunction

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " busy"},      64'(busy),      64'(0));
    checkOutput({tag, " done"},      64'(done),      64'(0));
    checkOutput({tag, " row_req"},   64'(row_req),   64'(0));
    checkOutput({tag, " row_addr"},  64'(row_addr),  64'(0));
    checkOutput({tag, " res_valid"}, 64'(res_valid), 64'(0));
    checkOutput({tag, " res_data"},  64'(res_data),  64'(0));
    checkOutput({tag, " res_index"}, 64'(res_index), 64'(0));
  endtask

  // Start is driven in the current cycle; vec_in is scrambled right after.
  task automatic applyStimulus(input vecT v);
    start  = 1'b1;
    vec_in = v;
    tick();
    start  = 1'b0;
    vec_in = randVec();
  endtask

  task automatic runJob(input string name, input vecT v, input vecT r0, input vecT r1,
                        input int vldDelay, input int readyDelay,
                        input bit midStart, input bit chain);
    vecT         rowsArr [ROWS];
    logic [63:0] expRes;
    int          cycles;
    rowsArr[0] = r0;
    rowsArr[1] = r1;
    cycles     = 0;
    applyStimulus(v);
    checkOutput({name, " start busy"},    64'(busy),    64'(1));
    checkOutput({name, " start row_req"}, 64'(row_req), 64'(1));
    for (int r = 0; r < ROWS; r++) begin
      for (int d = 0; d < vldDelay; d++) begin
        checkOutput({name, " stall row_req"},  64'(row_req),  64'(1));
        checkOutput({name, " stall row_addr"}, 64'(row_addr), 64'(r));
        tick();
        cycles++;
      end
      checkOutput({name, " row_addr"}, 64'(row_addr), 64'(r));
      row_vld  = 1'b1;
      row_data = rowsArr[r];
      tick();
      cycles++;
      row_vld  = 1'b0;
      row_data = randVec();
      checkOutput({name, " calc res_valid"}, 64'(res_valid), 64'(0));
      tick();
      cycles++;
      expRes = refDot(v, rowsArr[r]);
      checkOutput({name, " res_valid"}, 64'(res_valid), 64'(1));
      checkOutput({name, " res_data"},  64'(res_data),  expRes);
      checkOutput({name, " res_index"}, 64'(res_index), 64'(r));
      for (int d = 0; d < readyDelay; d++) begin
        row_vld = 1'b1;
        if (midStart && r == 0 && d == 0) begin
          start  = 1'b1;
          vec_in = ~v;
        end
        tick();
        cycles++;
        start = 1'b0;
        checkOutput({name, " hold res_data"},  64'(res_data),  expRes);
        checkOutput({name, " hold res_index"}, 64'(res_index), 64'(r));
        checkOutput({name, " hold row_req"},   64'(row_req),   64'(0));
        checkOutput({name, " hold res_valid"}, 64'(res_valid), 64'(1));
      end
      row_vld   = 1'b0;
      res_ready = 1'b1;
      tick();
      cycles++;
      res_ready = 1'b0;
      if (r < ROWS - 1) begin
        checkOutput({name, " next row_req"},  64'(row_req),  64'(1));
        checkOutput({name, " next row_addr"}, 64'(row_addr), 64'(r + 1));
        checkOutput({name, " next done"},     64'(done),     64'(0));
      end else begin
        checkOutput({name, " done pulse"},    64'(done),      64'(1));
        checkOutput({name, " done busy"},     64'(busy),      64'(0));
        checkOutput({name, " done res_valid"}, 64'(res_valid), 64'(0));
      end
    end
    if (vldDelay == 0 && readyDelay == 0) begin
      checkOutput({name, " throughput"}, 64'(cycles), 64'(3 * ROWS));
    end
    if (!chain) begin
      tick();
      checkOutput({name, " done cleared"}, 64'(done),    64'(0));
      checkOutput({name, " idle busy"},    64'(busy),    64'(0));
      checkOutput({name, " idle row_req"}, 64'(row_req), 64'(0));
    end
  endtask

  initial begin
    vecT vA, rA, rB;

    rst       = 1'b1;
    start     = 1'b0;
    vec_in    = '0;
    row_vld   = 1'b0;
    row_data  = '0;
    res_ready = 1'b0;
    tick();
    tick();
    checkIdleZero("reset");
    rst = 1'b0;
    tick();

    $display("[TB] basic job");
    for (int i = 0; i < VS; i++) begin
      vA[i] = DW'(i);
      rA[i] = DW'(i + 4);
      rB[i] = DW'(1);
    end
    runJob("basic", vA, rA, rB, 0, 0, 1'b0, 1'b0);

    $display("[TB] wrap-around");
    for (int i = 0; i < VS; i++) begin
      vA[i] = DW'(1 << 30);
      rA[i] = DW'(2);
    end
    runJob("wrap", vA, rA, rA, 0, 0, 1'b0, 1'b0);

    $display("[TB] backpressure and slow memory");
    runJob("stall", randVec(), randVec(), randVec(), 4, 5, 1'b0, 1'b0);

    $display("[TB] ignored start mid-job");
    runJob("midstart", randVec(), randVec(), randVec(), 1, 2, 1'b1, 1'b0);

    $display("[TB] reset mid-job");
    vA = randVec();
    applyStimulus(vA);
    row_vld  = 1'b1;
    row_data = randVec();
    tick();
    row_vld = 1'b0;
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    row_vld   = 1'b1;
    row_data  = randVec();
    tick();
    row_vld = 1'b0;
    tick();
    checkOutput("abort pre res_valid", 64'(res_valid), 64'(1));
    checkOutput("abort pre res_index", 64'(res_index), 64'(1));
    rst       = 1'b1;
    res_ready = 1'b1;
    tick();
    rst       = 1'b0;
    res_ready = 1'b0;
    checkIdleZero("abort");
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("abort no done", 64'(done), 64'(0));
      checkOutput("abort no busy", 64'(busy), 64'(0));
    end

    $display("[TB] fresh job then back-to-back");
    runJob("fresh", randVec(), randVec(), randVec(), 0, 0, 1'b0, 1'b1);
    runJob("b2b", randVec(), randVec(), randVec(), 0, 1, 1'b0, 1'b0);

    $display("[TB] randomized jobs");
    for (int k = 0; k < 8; k++) begin
      runJob("rand", randVec(), randVec(), randVec(),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
